uart_core_param: RTL
====================

Name: uart_core_param

Overview:
- Parametrised next-generation UART: configurable data width, parity mode, stop-bit count and FIFO depth on both TX and RX.
- Adds sticky parity, framing and overrun error flags, plus false-start rejection on RX.
- Contains its own 16x baud tick generator, TX FIFO + serialiser and RX synchroniser + deserialiser + FIFO.
- Sits between the board serial pins and application logic such as the typewriter/console controllers.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal 5..9.
- BAUDRATE, 19200, line rate in bit/s.
- FREQUENCY, 100000000, clock frequency in Hz.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits transmitted (1 or 2); RX checks only the first.
- FIFO_DEPTH, 16, entries per FIFO; power of two, 2..64.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- write_to_uart  in  1  push tx_data into TX FIFO
- tx_data  in  DATA_BITS  word to transmit
- tx_full  out  1  TX FIFO full
- tx_busy  out  1  serialiser active or TX FIFO non-empty
- tx  out  1  serial output, idle high
- rx  in  1  serial input (asynchronous)
- read_from_uart  in  1  pop RX FIFO head
- rx_data  out  DATA_BITS  RX FIFO head, first-word fall-through
- rx_data_present  out  1  RX FIFO non-empty
- rx_full  out  1  RX FIFO full
- parity_error  out  1  sticky
- framing_error  out  1  sticky
- overrun_error  out  1  sticky
- clear_errors  in  1  clears all three sticky flags

Behaviour:
- Reset (synchronous, active-high) values: tx=1, tx_full=0, tx_busy=0, rx_data_present=0, rx_full=0, rx_data=0, all error flags=0. Reset clears both FIFOs, the baud counter and both FSMs. Reset mid-frame aborts the frame; tx returns high on the next cycle.
- Baud: DIV = FREQUENCY/(BAUDRATE*16), integer-truncated, minimum 1. Counter runs 0..DIV-1; a one-cycle tick is produced when it wraps. A bit period is 16 ticks.
- TX FIFO write:
  - write_to_uart with tx_full=0 stores tx_data on the same edge.
  - A write while full is ignored; stored data is unchanged.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when the FIFO is non-empty, pop the head into the shift register and go to START on the next tick.
  - START: tx=0 for 16 ticks.
  - DATA: DATA_BITS bits, LSB first, 16 ticks each.
  - PARITY: only if PARITY!=0; odd means total ones in data+parity is odd, even means even.
  - STOP: tx=1 for 16*STOP_BITS ticks, then return to IDLE. Back-to-back frames have no extra idle gap.
- RX synchroniser: two flops, both reset to 1. All RX logic uses the synchronised signal.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a 1-to-0 transition enters START with the tick count cleared.
  - START: sample at tick 8. If the line is high, it is a false start; return to IDLE with no flags set.
  - DATA / PARITY / STOP: each bit is sampled 16 ticks after the previous sample (bit centre).
- Frame completion at the STOP sample:
  - Stop bit = 0: set framing_error and discard the word.
  - Parity mismatch: set parity_error and discard the word.
  - Otherwise push the word. If the RX FIFO is full and read_from_uart is not asserted in the same cycle: discard the word, set overrun_error, leave contents unchanged. A simultaneous pop and push when full is accepted.
  - After the STOP sample, the FSM returns to IDLE immediately so the next start edge can be detected.
- RX FIFO read:
  - rx_data always shows the head entry.
  - read_from_uart with rx_data_present=1 advances the head on that edge.
  - A read while empty is ignored.
  - Push into an empty FIFO: rx_data_present rises on the cycle after the push edge.
- Sticky error flags hold until clear_errors or reset. If clear_errors and a new error occur in the same cycle, the flag is set (set wins).
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty are decoded from the MSB comparison. Wrap-around must be exact at depth.

Test Plan:
(All scenarios use FREQUENCY=1600000 and BAUDRATE=100000, giving DIV=1 and 16 clocks per bit. Loopback means tx is tied to rx.)
1. DATA_BITS=8, PARITY=0, loopback, write 0xA5 → tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each level held 16 clocks (160 total). rx_data=0xA5 and rx_data_present=1 after the stop sample; no error flags.
2. PARITY=2, write 0x07 → parity bit 1 on tx. Inject 0x07 with parity bit forced to 0 on rx → parity_error=1, rx_data_present stays 0.
3. Drive rx low for 4 clocks, then high → no word, no flags, FSM back in IDLE. Then drive a frame with stop bit=0 → framing_error=1, word discarded.
4. FIFO_DEPTH=4, write 5 words back-to-back without tx running → tx_full=1 after the 4th write, 5th write ignored. Exactly 4 frames are transmitted in order.
5. FIFO_DEPTH=4, loopback, send 5 words with no reads → rx_full=1, overrun_error=1, first 4 words read out intact. Pulse clear_errors → overrun_error=0.
6. Assert reset mid-DATA of a TX frame → tx=1 on the next cycle, FIFOs empty, all outputs at reset values. A subsequent write of 0x3C transmits correctly.

Source files
------------

// File: rtl/uart_core_param.sv
`timescale 1ns/1ps
// Parametrised UART: 16x baud tick generator, TX FIFO + serialiser, RX synchroniser,
// deserialiser and FIFO, with sticky parity/framing/overrun flags and false-start rejection.
module uart_core_param #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned BAUDRATE   = 19200,
    parameter int unsigned FREQUENCY  = 100000000,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 write_to_uart,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_full,
    output logic                 tx_busy,
    output logic                 tx,
    input  logic                 rx,
    input  logic                 read_from_uart,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_data_present,
    output logic                 rx_full,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun_error,
    input  logic                 clear_errors
);

    localparam int unsigned DIV_RAW = FREQUENCY / (BAUDRATE * 16);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned BAUD_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned PW      = AW + 1;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // Baud tick generator
    logic [BAUD_W-1:0] baud_cnt;
    logic              tick_c;

    assign tick_c = (baud_cnt == BAUD_W'(DIV - 1));

    always_ff @(posedge clock) begin
        if (reset || tick_c) baud_cnt <= '0;
        else                 baud_cnt <= BAUD_W'(baud_cnt + 1'b1);
    end

    // TX FIFO
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [PW-1:0]        tx_wr, tx_rd;
    logic                 tx_empty_c, tx_push_c, tx_pop_c;
    logic [DATA_BITS-1:0] tx_head_c;

    assign tx_empty_c = (tx_wr == tx_rd);
    assign tx_full    = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
    assign tx_push_c  = write_to_uart && !tx_full;
    assign tx_head_c  = tx_mem[tx_rd[AW-1:0]];

    always_ff @(posedge clock) begin
        if (tx_push_c) tx_mem[tx_wr[AW-1:0]] <= tx_data;
    end

    // TX serialiser
    tx_state_t            tx_state, tx_state_next;
    logic [CNT_W-1:0]     tx_tick_cnt, tx_bit_cnt;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par, tx_line_c, tx_bit_end_c;

    assign tx_bit_end_c = tick_c && (tx_tick_cnt == 4'd15);
    assign tx_busy      = (tx_state != TX_IDLE) || !tx_empty_c;

    always_ff @(posedge clock) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_pop_c      = 1'b0;
        tx_line_c     = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (tick_c && !tx_empty_c) begin
                    tx_state_next = TX_START;
                    tx_pop_c      = 1'b1;
                end
            end
            TX_START: begin
                tx_line_c = 1'b0;
                if (tx_bit_end_c) tx_state_next = TX_DATA;
            end
            TX_DATA: begin
                tx_line_c = tx_shift[0];
                if (tx_bit_end_c && tx_bit_cnt == CNT_W'(DATA_BITS - 1))
                    tx_state_next = (PARITY != 0) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                tx_line_c = tx_par;
                if (tx_bit_end_c) tx_state_next = TX_STOP;
            end
            TX_STOP: begin
                // Chain straight into the next frame so there is no idle gap
                if (tx_bit_end_c && tx_bit_cnt == CNT_W'(STOP_BITS - 1)) begin
                    if (!tx_empty_c) begin
                        tx_state_next = TX_START;
                        tx_pop_c      = 1'b1;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_wr       <= '0;
            tx_rd       <= '0;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            tx          <= 1'b1;
        end else begin
            tx <= tx_line_c;
            if (tx_push_c) tx_wr <= PW'(tx_wr + 1'b1);
            if (tx_pop_c) begin
                tx_rd    <= PW'(tx_rd + 1'b1);
                tx_shift <= tx_head_c;
                tx_par   <= (PARITY == 1) ? ~(^tx_head_c) : (^tx_head_c);
            end
            if (tx_state_next != tx_state) begin
                tx_tick_cnt <= '0;
                tx_bit_cnt  <= '0;
            end else if (tick_c) begin
                tx_tick_cnt <= CNT_W'(tx_tick_cnt + 1'b1);
                if (tx_tick_cnt == 4'd15) begin
                    tx_bit_cnt <= CNT_W'(tx_bit_cnt + 1'b1);
                    if (tx_state == TX_DATA) tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                end
            end
        end
    end

    // RX synchroniser; rx_prev gives the falling-edge detector its history
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX deserialiser
    rx_state_t            rx_state, rx_state_next;
    logic [CNT_W-1:0]     rx_tick_cnt, rx_bit_cnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par, rx_sample_c, rx_done_c, par_bad_c;

    assign rx_sample_c = tick_c && (rx_tick_cnt == ((rx_state == RX_START) ? 4'd7 : 4'd15));

    always_ff @(posedge clock) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_state_next;
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_done_c     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) rx_state_next = RX_START;
            end
            RX_START: begin
                if (rx_sample_c) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_sample_c && rx_bit_cnt == CNT_W'(DATA_BITS - 1))
                    rx_state_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (rx_sample_c) rx_state_next = RX_STOP;
            end
            RX_STOP: begin
                if (rx_sample_c) begin
                    rx_state_next = RX_IDLE;
                    rx_done_c     = 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        par_bad_c = 1'b0;
        if (PARITY == 1)      par_bad_c = ~(^{rx_par, rx_shift});
        else if (PARITY == 2) par_bad_c = ^{rx_par, rx_shift};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_shift    <= '0;
            rx_par      <= 1'b0;
        end else begin
            if (rx_sample_c && rx_state == RX_DATA) rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_sample_c && rx_state == RX_PARITY) rx_par <= rx_sync;
            if (rx_state_next != rx_state) begin
                rx_tick_cnt <= '0;
                rx_bit_cnt  <= '0;
            end else if (tick_c) begin
                rx_tick_cnt <= CNT_W'(rx_tick_cnt + 1'b1);
                if (rx_sample_c) rx_bit_cnt <= CNT_W'(rx_bit_cnt + 1'b1);
            end
        end
    end

    // Frame completion: framing beats parity, overrun only for otherwise good words
    logic good_c, set_frame_c, set_par_c, set_over_c, rx_push_c, rx_pop_c;

    assign set_frame_c = rx_done_c && !rx_sync;
    assign set_par_c   = rx_done_c && rx_sync && par_bad_c;
    assign good_c      = rx_done_c && rx_sync && !par_bad_c;
    assign rx_pop_c    = read_from_uart && rx_data_present;
    assign rx_push_c   = good_c && (!rx_full || read_from_uart);
    assign set_over_c  = good_c && rx_full && !read_from_uart;

    // RX FIFO, first-word fall-through
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0]        rx_wr, rx_rd;

    assign rx_data_present = (rx_wr != rx_rd);
    assign rx_full         = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
    assign rx_data         = rx_mem[rx_rd[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_wr <= '0;
            rx_rd <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) rx_mem[i] <= '0;
        end else begin
            if (rx_push_c) begin
                rx_mem[rx_wr[AW-1:0]] <= rx_shift;
                rx_wr                 <= PW'(rx_wr + 1'b1);
            end
            if (rx_pop_c) rx_rd <= PW'(rx_rd + 1'b1);
        end
    end

    // Sticky flags; a new error in the clearing cycle wins
    always_ff @(posedge clock) begin
        if (reset) begin
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            parity_error  <= set_par_c   | (parity_error  & ~clear_errors);
            framing_error <= set_frame_c | (framing_error & ~clear_errors);
            overrun_error <= set_over_c  | (overrun_error & ~clear_errors);
        end
    end

endmodule
